// File: rtl/binary_div_8_4_seq.sv
// ============================================================================
// Module   : binary_div_8_4_seq
// Brief    : 8-bit / 4-bit unsigned sequential restoring divider, one
//            quotient bit per enabled cycle, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_div_8_4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] N,
  input  logic [3:0] D,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [4:0] rem_q,   rem_d;
  logic [7:0] dvd_q,   dvd_d;
  logic [3:0] dvs_q,   dvs_d;
  logic [6:0] quo_q,   quo_d;
  logic [7:0] q_q,     q_d;
  logic [3:0] r_q,     r_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       dbz_q,   dbz_d;

  logic [5:0] rem_shift;
  logic [4:0] rem_diff;
  logic [4:0] rem_next;
  logic       rem_ge;
  logic [7:0] quo_next;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, dvd_q[7]};
    rem_ge    = (rem_shift >= {2'b00, dvs_q});
    rem_diff  = rem_shift[4:0] - {1'b0, dvs_q};
    rem_next  = rem_ge ? rem_diff : rem_shift[4:0];
    quo_next  = {quo_q, rem_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (en && start) begin
          dvd_d = N;
          dvs_d = D;
          rem_d = 5'd0;
          cnt_d = 3'd0;
          quo_d = 7'd0;
          if (D != 4'h0) begin
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            // Zero divisor: saturated result is published on the accepting edge.
            q_d     = 8'hFF;
            r_d     = 4'hF;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_RUN: begin
        if (en) begin
          rem_d = rem_next;
          quo_d = quo_next[6:0];
          dvd_d = {dvd_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            q_d     = quo_next;
            r_d     = rem_next[3:0];
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      // Leaves on the very next edge regardless of en so done is one cycle wide.
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rem_q   <= 5'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      quo_q   <= 7'd0;
      q_q     <= 8'h00;
      r_q     <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: doc/binary_div_8_4_seq.md
BINARY_DIV_8_4_SEQ -- requirements
Module: binary_div_8_4_seq

Interface
REQ-001 Parameters: none; widths fixed at 8-bit dividend / 4-bit divisor (inverse of the 4x4 array multiplier; Q*D+R reconstructs N).
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  advance enable; when 0, all state and outputs hold.
REQ-005 start  input  1  request a division; sampled only when en=1 and state IDLE.
REQ-006 N  input  8  unsigned dividend, sampled with accepted start.
REQ-007 D  input  4  unsigned divisor, sampled with accepted start.
REQ-008 Q  output  8  unsigned quotient, registered.
REQ-009 R  output  4  unsigned remainder, registered.
REQ-010 busy  output  1  high from accepted start until result written.
REQ-011 done  output  1  one-cycle pulse on result write.
REQ-012 div_by_zero  output  1  registered flag for last result, set when D was 0.

Function
REQ-013 Algorithm: restoring division, MSB first, one quotient bit per enabled cycle; 5-bit partial remainder; compare/subtract against {1'b0,D}.
REQ-014 States: IDLE, RUN, DONE; 3-bit iteration counter 0..7.
REQ-015 IDLE: on edge with en=1 and start=1, latch N and D, clear partial remainder and counter, set busy=1; if D!=0 go RUN, else go DONE.
REQ-016 RUN: each edge with en=1: shift partial remainder left taking next dividend bit; if result >= D subtract and set quotient bit 1, else quotient bit 0; increment counter.
REQ-017 RUN: edge performing iteration 7 writes Q, R, div_by_zero=0, done=1, busy=0, moves to DONE.
REQ-018 D=0 path: the DONE-entry edge writes Q=8'hFF, R=4'hF, div_by_zero=1, done=1, busy=0.
REQ-019 DONE: next clock edge (independent of en) clears done and returns to IDLE; done high exactly one cycle.
REQ-020 Latency with en held 1: done high in the cycle following the 8th edge after the start edge (D!=0); following the 1st edge (D=0).
REQ-021 en=0 in RUN freezes counter and partial remainder; latency stretches by number of en=0 cycles; result unaffected.
REQ-022 start while busy or in DONE is ignored; N and D changes after acceptance do not affect the result.
REQ-023 Q, R, div_by_zero hold last result until next result write; never show intermediate values.
REQ-024 Invariant for D!=0: Q*D+R == N and R < D.

Reset
REQ-025 rst_n=0 asynchronously forces IDLE, counter=0, partial remainder=0, Q=8'h00, R=4'h0, busy=0, done=0, div_by_zero=0.
REQ-026 Reset mid-operation aborts the division; no done pulse is produced; next start after rst_n=1 runs normally.

Verification
REQ-027 N=200, D=7, en=1 -> after 8 edges done=1, Q=28 (8'h1C), R=4, div_by_zero=0.
REQ-028 N=255, D=15 -> Q=17, R=0; N=5, D=9 -> Q=0, R=5; N=0, D=1 -> Q=0, R=0.
REQ-029 N=13, D=0 -> done after 1 edge, Q=8'hFF, R=4'hF, div_by_zero=1; next division with D=3 clears flag.
REQ-030 N=200, D=7 with en=0 for 3 cycles mid-RUN -> done after 11 edges, Q=28, R=4; start pulsed during RUN ignored.
REQ-031 rst_n low at iteration 4 -> outputs zero immediately, no done; restart N=100, D=9 -> Q=11, R=1.
REQ-032 Exhaustive sweep all N (0..255) x D (1..15) against REQ-024 with random en gaps; zero mismatches.
